// File: rtl/usart_tx_arbiter_pkg.sv
// Shared definitions for the USART transmit path: byte width and the
// arbiter state encoding, also used by the usart_tx/usart_rx blocks.
package usart_tx_arbiter_pkg;

    localparam int USART_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/usart_tx_arbiter_if.sv
// Requester / transmitter bundle seen by the arbiter. The slave modport is the
// arbiter; the master modport is the client-plus-transmitter side.
interface usart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import usart_tx_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ*USART_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [USART_DATA_WIDTH-1:0]         tx_data;
    logic                                tx_valid;
    logic                                tx_ready;
    logic                                cts;
    logic [NUM_REQ-1:0]                  grant;
    logic                                busy;

    modport master (
        output req_valid, req_data, req_last, tx_ready, cts,
        input  req_ready, tx_data, tx_valid, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready, cts,
        output req_ready, tx_data, tx_valid, grant, busy
    );

endinterface

// File: rtl/usart_tx_arbiter_rr_priority_select.sv
// Round-robin priority picker: first set request at or after ptr, with wrap.
// Purely combinational so it can be reused by an rx-side router.
module rr_priority_select #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan requests starting at ptr and keep the first hit.
    always_comb begin
        pick    = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                pick[cand_s] = 1'b1;
                idx          = cand_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one USART transmitter between
// NUM_REQ byte streams, with burst-length and idle-timeout forced release.
module usart_tx_arbiter
    import usart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                comm_clock,
    input  logic                reset,
    usart_tx_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam int IW    = $clog2(IDLE_TIMEOUT + 1);
    localparam int DW    = USART_DATA_WIDTH;

    arb_state_e         state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic               busy_r, busy_s;
    logic [IDX_W-1:0]   gidx_r, gidx_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [BW-1:0]      burst_cnt_r, burst_cnt_s;
    logic [IW-1:0]      idle_cnt_r, idle_cnt_s;

    logic [NUM_REQ-1:0] pick_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               gvalid_s, glast_s, xfer_s, release_s;
    logic [DW-1:0]      tx_data_s;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
        .req  (bus.req_valid),
        .ptr  (rr_ptr_r),
        .pick (pick_s),
        .idx  (pick_idx_s)
    );

    // Byte mux from the granted requester; all-zero when nobody owns the port.
    always_comb begin
        tx_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_r[k]) begin
                tx_data_s = tx_data_s | bus.req_data[k*DW +: DW];
            end else begin
                tx_data_s = tx_data_s;
            end
        end
    end

    assign gvalid_s      = |(bus.req_valid & grant_r);
    assign glast_s       = |(bus.req_last & grant_r);
    assign bus.tx_valid  = gvalid_s & bus.cts;
    assign bus.tx_data   = tx_data_s;
    assign bus.req_ready = grant_r & {NUM_REQ{bus.tx_ready & bus.cts}};
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;
    assign xfer_s        = bus.tx_valid & bus.tx_ready;

    // Arbitration FSM next-state, counters and release decision.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        busy_s      = busy_r;
        gidx_s      = gidx_r;
        rr_ptr_s    = rr_ptr_r;
        burst_cnt_s = burst_cnt_r;
        idle_cnt_s  = idle_cnt_r;
        release_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (|bus.req_valid) begin
                    state_s     = ARB_GRANT;
                    grant_s     = pick_s;
                    busy_s      = 1'b1;
                    gidx_s      = pick_idx_s;
                    burst_cnt_s = '0;
                    idle_cnt_s  = '0;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (xfer_s && (burst_cnt_r != BW'(MAX_BURST))) begin
                    burst_cnt_s = burst_cnt_r + 1'b1;
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
                // Idle time only counts while the peer could actually receive.
                if (gvalid_s) begin
                    idle_cnt_s = '0;
                end else if (bus.cts && (idle_cnt_r != IW'(IDLE_TIMEOUT))) begin
                    idle_cnt_s = idle_cnt_r + 1'b1;
                end else begin
                    idle_cnt_s = idle_cnt_r;
                end
                if (xfer_s && (glast_s || (burst_cnt_s == BW'(MAX_BURST)))) begin
                    release_s = 1'b1;
                end else if (idle_cnt_s == IW'(IDLE_TIMEOUT)) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
                if (release_s) begin
                    state_s  = ARB_IDLE;
                    grant_s  = '0;
                    busy_s   = 1'b0;
                    rr_ptr_s = (gidx_r == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_r + 1'b1;
                end else begin
                    state_s = ARB_GRANT;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state_r     <= ARB_IDLE;
            grant_r     <= '0;
            busy_r      <= 1'b0;
            gidx_r      <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            idle_cnt_r  <= '0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            busy_r      <= busy_s;
            gidx_r      <= gidx_s;
            rr_ptr_r    <= rr_ptr_s;
            burst_cnt_r <= burst_cnt_s;
            idle_cnt_r  <= idle_cnt_s;
        end
    end

endmodule
